// File: rtl/cordic_scheduler_if.sv
// Requester-side request/response bundle of cordic_scheduler.
// The scheduler takes the slave modport; requester front-ends take the master modport.
interface cordic_scheduler_if #(
    parameter int NUM_REQ     = 2,
    parameter int FIXED_WIDTH = 16,
    parameter int SHIFT_W     = 4
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [2*NUM_REQ-1:0]           req_mode;
    logic [NUM_REQ-1:0]             req_rot;
    logic [SHIFT_W*NUM_REQ-1:0]     req_shift;
    logic [FIXED_WIDTH*NUM_REQ-1:0] req_a;
    logic [FIXED_WIDTH*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [FIXED_WIDTH-1:0]         rsp_out1;
    logic [FIXED_WIDTH-1:0]         rsp_out2;
    logic                           rsp_err;

    modport master (
        output req_valid, req_mode, req_rot, req_shift, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_out1, rsp_out2, rsp_err
    );

    modport slave (
        input  req_valid, req_mode, req_rot, req_shift, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_out1, rsp_out2, rsp_err
    );
endinterface

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC engine among NUM_REQ requesters.
// Define CORDIC_SCHED_TIMEOUT_EN to abort a BUSY wait after TIMEOUT cycles with rsp_err.
module cordic_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int FIXED_WIDTH = 16,
    parameter int SHIFT_W     = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cordic_scheduler_if.slave      bus,
    output logic                   core_start,
    output logic [1:0]             core_mode,
    output logic                   core_rot,
    output logic [SHIFT_W-1:0]     core_shift,
    output logic [FIXED_WIDTH-1:0] core_a,
    output logic [FIXED_WIDTH-1:0] core_b,
    input  logic [FIXED_WIDTH-1:0] core_out1,
    input  logic [FIXED_WIDTH-1:0] core_out2,
    input  logic                   core_done,
    output logic                   busy
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_nxt;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    logic [ID_W:0]   scan_idx;
    logic            illegal_mode;
    logic            rsp_hs;
    logic            timed_out;

    assign illegal_mode = (core_mode == 2'b11);
    assign rsp_hs       = (state == S_RESP) && bus.rsp_ready[grant_id];
    assign rr_nxt       = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (scan_idx >= (ID_W + 1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!pick_vld && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = scan_idx[ID_W-1:0];
            end
        end
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != S_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timed_out = (state == S_BUSY) && !core_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        core_start    = 1'b0;
        busy          = (state != S_IDLE);
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (state == S_IDLE) && pick_vld && (pick_id == ID_W'(i));
            bus.rsp_valid[i] = (state == S_RESP) && (grant_id == ID_W'(i));
        end
        case (state)
            S_IDLE: begin
                if (pick_vld) state_nxt = S_ISSUE;
            end
            // Illegal mode passes through ISSUE without starting the engine.
            S_ISSUE: begin
                core_start = !illegal_mode;
                state_nxt  = illegal_mode ? S_RESP : S_BUSY;
            end
            S_BUSY: begin
                if (core_done || timed_out) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            core_mode    <= '0;
            core_rot     <= 1'b0;
            core_shift   <= '0;
            core_a       <= '0;
            core_b       <= '0;
            bus.rsp_out1 <= '0;
            bus.rsp_out2 <= '0;
            bus.rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_id   <= pick_id;
                        core_mode  <= bus.req_mode[2*pick_id +: 2];
                        core_rot   <= bus.req_rot[pick_id];
                        core_shift <= bus.req_shift[SHIFT_W*pick_id +: SHIFT_W];
                        core_a     <= bus.req_a[FIXED_WIDTH*pick_id +: FIXED_WIDTH];
                        core_b     <= bus.req_b[FIXED_WIDTH*pick_id +: FIXED_WIDTH];
                    end
                end
                S_ISSUE: begin
                    if (illegal_mode) begin
                        bus.rsp_out1 <= '0;
                        bus.rsp_out2 <= '0;
                        bus.rsp_err  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (core_done) begin
                        bus.rsp_out1 <= core_out1;
                        bus.rsp_out2 <= core_out2;
                        bus.rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        bus.rsp_out1 <= '0;
                        bus.rsp_out2 <= '0;
                        bus.rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rr_ptr       <= rr_nxt;
                        bus.rsp_out1 <= '0;
                        bus.rsp_out2 <= '0;
                        bus.rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler with a stub engine (done 10 cycles after start,
// out1 = A+B, out2 = A-B); a negedge monitor checks grants, operands, latency and responses.
module tb_cordic_scheduler;
    localparam int NR = 2;
    localparam int FW = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_scheduler_if #(.NUM_REQ(NR), .FIXED_WIDTH(FW), .SHIFT_W(SW)) ifc ();

    logic          core_start;
    logic [1:0]    core_mode;
    logic          core_rot;
    logic [SW-1:0] core_shift;
    logic [FW-1:0] core_a, core_b;
    logic [FW-1:0] core_out1, core_out2;
    logic          core_done;
    logic          busy;

    cordic_scheduler #(
        .NUM_REQ(NR), .FIXED_WIDTH(FW), .SHIFT_W(SW), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .core_start(core_start), .core_mode(core_mode), .core_rot(core_rot),
        .core_shift(core_shift), .core_a(core_a), .core_b(core_b),
        .core_out1(core_out1), .core_out2(core_out2), .core_done(core_done),
        .busy(busy)
    );

    // Stub engine
    int stub_cnt;
    bit stub_hang;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt  <= 0;
            core_done <= 1'b0;
            core_out1 <= '0;
            core_out2 <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                stub_cnt <= 9;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_hang) begin
                    core_done <= 1'b1;
                    core_out1 <= core_a + core_b;
                    core_out2 <= core_a - core_b;
                end
            end
        end
    end

    typedef struct {
        int            id;
        logic [1:0]    mode;
        logic [SW-1:0] shift;
        logic [FW-1:0] a, b, o1, o2;
        logic          err;
        int            starts;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   acc_count = 0, acc_cyc = 0, hs_cyc = 0, starts = 0;
    bit   rsp_was = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_was = 1'b0;
        end else begin
            if (|ifc.req_ready) begin
                acc_count++;
                acc_cyc = cyc;
                starts  = 0;
                if (sb.size() == 0) check("unexpected_grant", 32'(ifc.req_ready), 32'h0);
                else                check("grant", 32'(ifc.req_ready), 32'(1 << sb[0].id));
            end
            if (core_start) begin
                starts++;
                if (sb.size() != 0) begin
                    check("start_lat", 32'(cyc - acc_cyc), 32'd1);
                    check("core_a", 32'(core_a), 32'(sb[0].a));
                    check("core_b", 32'(core_b), 32'(sb[0].b));
                    check("core_mode", 32'(core_mode), 32'(sb[0].mode));
                    check("core_shift", 32'(core_shift), 32'(sb[0].shift));
                end
            end
            if (|ifc.rsp_valid && !rsp_was && sb.size() != 0) begin
                check("rsp_lat", 32'(cyc - acc_cyc), 32'(sb[0].lat));
                check("start_count", 32'(starts), 32'(sb[0].starts));
            end
            if (|(ifc.rsp_valid & ifc.rsp_ready)) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(ifc.rsp_valid), 32'h0);
                end else begin
                    check("rsp_id", 32'(ifc.rsp_valid), 32'(1 << sb[0].id));
                    check("rsp_out1", 32'(ifc.rsp_out1), 32'(sb[0].o1));
                    check("rsp_out2", 32'(ifc.rsp_out2), 32'(sb[0].o2));
                    check("rsp_err", 32'(ifc.rsp_err), 32'(sb[0].err));
                    void'(sb.pop_front());
                end
                hs_cyc = cyc;
            end
            rsp_was = |ifc.rsp_valid;
        end
    end

    task automatic drive_req(int id, logic [1:0] mode, logic rot, logic [SW-1:0] sh,
                             logic [FW-1:0] a, logic [FW-1:0] b);
        ifc.req_mode[2*id +: 2]    = mode;
        ifc.req_rot[id]            = rot;
        ifc.req_shift[SW*id +: SW] = sh;
        ifc.req_a[FW*id +: FW]     = a;
        ifc.req_b[FW*id +: FW]     = b;
        ifc.req_valid[id]          = 1'b1;
    endtask

    task automatic expect_rsp(int id, logic [1:0] mode, logic [SW-1:0] sh, logic [FW-1:0] a,
                              logic [FW-1:0] b, logic [FW-1:0] o1, logic [FW-1:0] o2,
                              logic err, int st, int lat);
        exp_t e;
        e.id = id; e.mode = mode; e.shift = sh; e.a = a; e.b = b;
        e.o1 = o1; e.o2 = o2; e.err = err; e.starts = st; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_accepts(int target, int budget);
        int n = 0;
        while (acc_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("accept_wait", 32'(acc_count >= target), 32'd1);
    endtask

    task automatic wait_empty(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        stub_hang     = 1'b0;
        ifc.req_valid = '0;
        ifc.req_mode  = '0;
        ifc.req_rot   = '0;
        ifc.req_shift = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_core_a", 32'(core_a), 32'd0);
        check("rst_rsp_out1", 32'(ifc.rsp_out1), 32'd0);
        check("rst_rsp_err", 32'(ifc.rsp_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single circular op
        drive_req(0, 2'b00, 1'b1, 4'd3, 16'h1000, 16'h0200);
        expect_rsp(0, 2'b00, 4'd3, 16'h1000, 16'h0200, 16'h1200, 16'h0E00, 1'b0, 1, 12);
        wait_accepts(1, 20); #1 ifc.req_valid[0] = 1'b0;
        wait_empty(40); #1;

        // Illegal mode on req1
        drive_req(1, 2'b11, 1'b0, 4'd0, 16'h1234, 16'h0034);
        expect_rsp(1, 2'b11, 4'd0, 16'h1234, 16'h0034, 16'h0000, 16'h0000, 1'b1, 0, 2);
        wait_accepts(2, 20); #1 ifc.req_valid[1] = 1'b0;
        wait_empty(20); #1;

        // Both valid continuously: 0,1,0,1
        drive_req(0, 2'b00, 1'b0, 4'd0, 16'h0100, 16'h0001);
        drive_req(1, 2'b01, 1'b1, 4'd5, 16'h7000, 16'h1000);
        for (int k = 0; k < 2; k++) begin
            expect_rsp(0, 2'b00, 4'd0, 16'h0100, 16'h0001, 16'h0101, 16'h00FF, 1'b0, 1, 12);
            expect_rsp(1, 2'b01, 4'd5, 16'h7000, 16'h1000, 16'h8000, 16'h6000, 1'b0, 1, 12);
        end
        wait_accepts(6, 100); #1 ifc.req_valid = '0;
        wait_empty(100); #1;

        // Response back-pressure on req0 while req1 waits
        ifc.rsp_ready[0] = 1'b0;
        drive_req(0, 2'b10, 1'b1, 4'd2, 16'h0005, 16'h0007);
        expect_rsp(0, 2'b10, 4'd2, 16'h0005, 16'h0007, 16'h000C, 16'hFFFE, 1'b0, 1, 12);
        wait_accepts(7, 20); #1 ifc.req_valid[0] = 1'b0;
        drive_req(1, 2'b00, 1'b0, 4'd1, 16'h0002, 16'h0003);
        expect_rsp(1, 2'b00, 4'd1, 16'h0002, 16'h0003, 16'h0005, 16'hFFFF, 1'b0, 1, 12);
        begin
            int n = 0;
            while (!ifc.rsp_valid[0] && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        check("hold_seen", 32'(ifc.rsp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(ifc.rsp_valid), 32'h1);
            check("hold_out1", 32'(ifc.rsp_out1), 32'h000C);
            check("hold_out2", 32'(ifc.rsp_out2), 32'hFFFE);
            check("hold_no_grant", 32'(ifc.req_ready), 32'h0);
            check("hold_busy", 32'(busy), 32'h1);
        end
        @(posedge clk); #1 ifc.rsp_ready[0] = 1'b1;
        wait_accepts(8, 10);
        check("grant_after_hs", 32'(acc_cyc - hs_cyc), 32'd1);
        #1 ifc.req_valid[1] = 1'b0;
        wait_empty(40); #1;

        // Move rr pointer to 1, then reset while req1 is in BUSY
        drive_req(0, 2'b00, 1'b1, 4'd0, 16'h0010, 16'h0001);
        expect_rsp(0, 2'b00, 4'd0, 16'h0010, 16'h0001, 16'h0011, 16'h000F, 1'b0, 1, 12);
        wait_accepts(9, 20); #1 ifc.req_valid[0] = 1'b0;
        wait_empty(40); #1;
        drive_req(1, 2'b00, 1'b0, 4'd0, 16'h4444, 16'h1111);
        expect_rsp(1, 2'b00, 4'd0, 16'h4444, 16'h1111, 16'h5555, 16'h3333, 1'b0, 1, 12);
        wait_accepts(10, 20); #1 ifc.req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2 check("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_core_start", 32'(core_start), 32'd0);
        check("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("mid_rst_core_a", 32'(core_a), 32'd0);
        check("mid_rst_core_b", 32'(core_b), 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive_req(0, 2'b00, 1'b0, 4'd0, 16'h0300, 16'h0100);
        drive_req(1, 2'b01, 1'b1, 4'd7, 16'h0003, 16'h0001);
        expect_rsp(0, 2'b00, 4'd0, 16'h0300, 16'h0100, 16'h0400, 16'h0200, 1'b0, 1, 12);
        expect_rsp(1, 2'b01, 4'd7, 16'h0003, 16'h0001, 16'h0004, 16'h0002, 1'b0, 1, 12);
        wait_accepts(12, 60); #1 ifc.req_valid = '0;
        wait_empty(60); #1;

`ifdef CORDIC_SCHED_TIMEOUT_EN
        stub_hang = 1'b1;
        drive_req(0, 2'b00, 1'b0, 4'd0, 16'h0001, 16'h0001);
        expect_rsp(0, 2'b00, 4'd0, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1, 66);
        wait_accepts(13, 20); #1 ifc.req_valid[0] = 1'b0;
        wait_empty(150); #1;
        stub_hang = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/cordic_scheduler.md
Name: cordic_scheduler

Overview:
- Shares one iterative CORDIC engine between NUM_REQ independent requesters using a round-robin arbiter.
- Each request carries one complete operation: mode, rotate/vector, alpha shift, A, B.
- The scheduler latches the winning request, pulses the engine's start, waits for done, and returns out1/out2 to the originating requester through a valid/ready response.
- It sits between the peripheral register front-ends and the CORDIC core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- FIXED_WIDTH, 16, operand/result width
- SHIFT_W, 4, alpha shift width (= clog2(FIXED_WIDTH))
- TIMEOUT, 64, max cycles waiting for core_done (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_mode  in  2*NUM_REQ  per-requester mode (00 circular, 01 linear, 10 hyperbolic, 11 illegal)
- req_rot  in  NUM_REQ  per-requester is_rotating
- req_shift  in  SHIFT_W*NUM_REQ  per-requester alpha_one_left_shift
- req_a, req_b  in  FIXED_WIDTH*NUM_REQ  per-requester operands
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_out1, rsp_out2  out  FIXED_WIDTH  shared result bus
- rsp_err  out  1  response error flag
- core_start  out  1  one-cycle start pulse to the engine
- core_mode  out  2  latched mode
- core_rot  out  1  latched is_rotating
- core_shift  out  SHIFT_W  latched shift
- core_a, core_b  out  FIXED_WIDTH  latched operands
- core_out1, core_out2  in  FIXED_WIDTH  engine results
- core_done  in  1  engine one-cycle done pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE, rr pointer 0, all outputs 0, core_* latches 0.
- IDLE:
  - If any req_valid, grant the first valid index at or after the rr pointer (wrapping).
  - req_ready[g]=1 combinationally in this cycle only.
  - Latch mode/rot/shift/A/B into core_* and g into grant_id.
  - Next state is ISSUE. If the latched mode is 11, next state is RESP with rsp_err=1 and results 0; the engine is not started.
- ISSUE: core_start=1 for exactly one cycle -> BUSY.
- BUSY:
  - Wait for core_done.
  - On the core_done cycle, capture core_out1/core_out2 into rsp_out1/rsp_out2, set rsp_err=0 -> RESP.
  - core_start stays 0.
- RESP:
  - rsp_valid[grant_id]=1; rsp_out1, rsp_out2 and rsp_err are held stable until rsp_ready[grant_id]=1.
  - On the handshake: rr pointer = grant_id+1 (wraps to 0 after NUM_REQ-1) -> IDLE; rsp_* cleared to 0.
- Latency: request accept to core_start = 1 cycle; core_done to rsp_valid = 1 cycle. Minimum accept-to-accept gap = engine latency + 3 cycles.
- Only one operation is in flight; req_ready is 0 outside IDLE.
- rsp_ready on a non-granted index is ignored.
- req_valid deasserting while not granted is allowed; the request is simply not granted.
- core_done received outside BUSY is ignored.
- Reset mid-operation: immediate return to IDLE, responses dropped, core_start 0.
- The engine is assumed to be reset by the same rst_n.
- busy = (state != IDLE).

Optional Feature:
- Macro: CORDIC_SCHED_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no core_done, go to RESP with rsp_err=1 and rsp_out1=rsp_out2=0.
  - A late core_done arriving after the timeout is ignored.
- When undefined: no counter; BUSY waits indefinitely; rsp_err is set only for illegal mode.

Test Plan:
- Stub core (done 10 cycles after start, out1=A+B, out2=A-B). Req0 with mode 00, rot 1, A=0x1000, B=0x0200 -> req_ready[0] in the accept cycle, core_start 1 cycle later, rsp_valid[0] with out1=0x1200, out2=0x0E00, rsp_err=0, arriving 12 cycles after accept.
- Req0 and req1 both valid continuously from reset -> grant order 0,1,0,1; core_a/b match the granted requester each time.
- Req1 mode=11 -> no core_start; rsp_valid[1] with rsp_err=1 and out1=out2=0, 2 cycles after accept.
- Hold rsp_ready[0]=0 for 5 cycles in RESP -> rsp_out1/out2 stable and no new grant; a new grant occurs in the cycle after the handshake.
- Assert rst_n low while in BUSY -> all outputs 0 immediately; a later request is served normally from rr pointer 0.
- With CORDIC_SCHED_TIMEOUT_EN and a stub that never asserts done, TIMEOUT=64 -> rsp_valid with rsp_err=1 exactly 64 BUSY cycles after core_start.
